gate_tt_checker: RTL and testbench

- Synthesizable truth-table exerciser and checker for one 2-input 74HC-series gate model (74HC32 OR, 74HC08 AND, 74HC00 NAND and similar).
- Drives the gate's two inputs through all four input vectors, waits a programmable settle time, samples the gate output and compares it against an expected truth table.
- Reports pass/fail, a mismatch count and the first failing vector.
- Used as an on-board or in-sim self-test companion next to the gate models in the TD4 datapath.

---
 rtl/gate_tt_checker.sv | 122 ++++++++++++
 tb/tb_gate_tt_checker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Walks a 2-input gate through vectors 00,10,01,11, holds each SETTLE_CYCLES, samples once, compares to TRUTH_TABLE.
// A full run takes 4*(SETTLE_CYCLES+1) cycles from the accepting edge; start is ignored while busy.
`timescale 1ns/1ps
module gate_tt_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1110,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       dut_in1,
    output logic       dut_in2,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_idx
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] err_q, err_d;
    logic       fvld_q, fvld_d;
    logic [1:0] fidx_q, fidx_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       pass_q, pass_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fvld_d   = fvld_q;
        fidx_d   = fidx_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SETTLE;
                    idx_d    = 2'd0;
                    vec_d    = 2'd0;
                    settle_d = 4'd0;
                    err_d    = 3'd0;
                    fvld_d   = 1'b0;
                    fidx_d   = 2'd0;
                    done_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (dut_out != TRUTH_TABLE[idx_q]) begin
                    err_d = err_q + 3'd1;
                    if (!fvld_q) begin
                        fvld_d = 1'b1;
                        fidx_d = idx_q;
                    end
                end
                if (idx_q == 2'd3) begin
                    vec_d   = 2'd0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    vec_d    = idx_q + 2'd1;
                    settle_d = 4'd0;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flags are registered from next-state so they line up with the state they describe.
        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        pass_d = done_d && (err_d == 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            vec_q    <= 2'd0;
            settle_q <= 4'd0;
            err_q    <= 3'd0;
            fvld_q   <= 1'b0;
            fidx_q   <= 2'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fvld_q   <= fvld_d;
            fidx_q   <= fidx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in1    = vec_q[0];
    assign dut_in2    = vec_q[1];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fvld_q;
    assign fail_idx   = fidx_q;
endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench: four checker instances (OR/AND tables, settle 1/2/15) driving a behavioural gate model.
`timescale 1ns/1ps
module tb_gate_tt_checker;
    localparam int M_OR = 0, M_ZERO = 1, M_AND = 2, M_NAND = 3;

    typedef struct {
        logic [2:0] err;
        logic       fv;
        logic [1:0] fi;
        logic       ps;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] start_r;
    int         gate_mode;
    logic [3:0] in1_w, in2_w, out_w, busy_w, done_w, pass_w, fv_w;
    logic [2:0] err_w [4];
    logic [1:0] fi_w  [4];
    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    function automatic logic gate_f(input int m, input logic a, input logic b);
        case (m)
            M_OR:    return a | b;
            M_AND:   return a & b;
            M_NAND:  return ~(a & b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] tt_of(input int k);
        return (k == 1) ? 4'b1000 : 4'b1110;
    endfunction

    function automatic int st_of(input int k);
        case (k)
            2:       return 1;
            3:       return 15;
            default: return 2;
        endcase
    endfunction

    assign out_w[0] = gate_f(gate_mode, in1_w[0], in2_w[0]);
    assign out_w[1] = gate_f(gate_mode, in1_w[1], in2_w[1]);
    assign out_w[2] = gate_f(gate_mode, in1_w[2], in2_w[2]);
    assign out_w[3] = gate_f(gate_mode, in1_w[3], in2_w[3]);

    gate_tt_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(2)) u_or (
        .clk(clk), .reset_n(reset_n), .start(start_r[0]), .dut_in1(in1_w[0]), .dut_in2(in2_w[0]),
        .dut_out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_valid(fv_w[0]), .fail_idx(fi_w[0]));
    gate_tt_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(2)) u_and (
        .clk(clk), .reset_n(reset_n), .start(start_r[1]), .dut_in1(in1_w[1]), .dut_in2(in2_w[1]),
        .dut_out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_valid(fv_w[1]), .fail_idx(fi_w[1]));
    gate_tt_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .start(start_r[2]), .dut_in1(in1_w[2]), .dut_in2(in2_w[2]),
        .dut_out(out_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_valid(fv_w[2]), .fail_idx(fi_w[2]));
    gate_tt_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(15)) u_s15 (
        .clk(clk), .reset_n(reset_n), .start(start_r[3]), .dut_in1(in1_w[3]), .dut_in2(in2_w[3]),
        .dut_out(out_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
        .err_count(err_w[3]), .fail_valid(fv_w[3]), .fail_idx(fi_w[3]));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag, input int k);
        chk({tag, "_in1"},  k, 32'(in1_w[k]),  0);
        chk({tag, "_in2"},  k, 32'(in2_w[k]),  0);
        chk({tag, "_busy"}, k, 32'(busy_w[k]), 0);
        chk({tag, "_done"}, k, 32'(done_w[k]), 0);
        chk({tag, "_pass"}, k, 32'(pass_w[k]), 0);
        chk({tag, "_err"},  k, 32'(err_w[k]),  0);
        chk({tag, "_fv"},   k, 32'(fv_w[k]),   0);
        chk({tag, "_fi"},   k, 32'(fi_w[k]),   0);
    endtask

    // Entered and left at posedge+#1. Expected results go on the scoreboard before start is driven.
    task automatic run(input int k, input int mode, input bit extra);
        exp_t       e, got;
        logic [1:0] vv;
        logic [3:0] tt;
        int         s, n, lat;
        s  = st_of(k);
        n  = 4 * (s + 1);
        tt = tt_of(k);
        gate_mode = mode;
        e.err = 3'd0; e.fv = 1'b0; e.fi = 2'd0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (gate_f(mode, vv[0], vv[1]) !== tt[v]) begin
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.fi = vv;
                end
                e.err = e.err + 3'd1;
            end
        end
        e.ps = (e.err == 3'd0);
        sb_q.push_back(e);

        start_r[k] = 1'b1;
        @(posedge clk); #1;
        start_r[k] = 1'b0;
        chk("accept_done", k, 32'(done_w[k]), 0);
        chk("accept_err",  k, 32'(err_w[k]),  0);
        chk("accept_fv",   k, 32'(fv_w[k]),   0);
        lat = 0;
        while (done_w[k] !== 1'b1 && lat < n + 20) begin
            chk("run_busy", k, 32'(busy_w[k]), 1);
            chk("run_vec",  k, 32'({in2_w[k], in1_w[k]}), 32'(lat / (s + 1)));
            start_r[k] = (extra && lat == 1);
            @(posedge clk); #1;
            lat++;
        end
        start_r[k] = 1'b0;
        chk("latency", k, 32'(lat), 32'(n));
        got = sb_q.pop_front();
        chk("done", k, 32'(done_w[k]), 1);
        chk("busy_after", k, 32'(busy_w[k]), 0);
        chk("vec_after", k, 32'({in2_w[k], in1_w[k]}), 0);
        chk("err_count", k, 32'(err_w[k]), 32'(got.err));
        chk("fail_valid", k, 32'(fv_w[k]), 32'(got.fv));
        if (got.fv) chk("fail_idx", k, 32'(fi_w[k]), 32'(got.fi));
        chk("pass", k, 32'(pass_w[k]), 32'(got.ps));
    endtask

    initial begin
        reset_n   = 1'b0;
        start_r   = 4'b0;
        gate_mode = M_OR;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk_all_zero("reset", k);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(0, M_OR,   1'b0);
        run(0, M_ZERO, 1'b0);
        run(1, M_AND,  1'b0);
        run(1, M_NAND, 1'b0);
        run(0, M_OR,   1'b1);
        run(2, M_OR,   1'b0);
        run(2, M_ZERO, 1'b0);
        run(3, M_OR,   1'b0);
        run(3, M_ZERO, 1'b0);

        // Abort mid-run: partial results from the zero-output model must vanish with reset.
        gate_mode  = M_ZERO;
        start_r[0] = 1'b1;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset_busy", 0, 32'(busy_w[0]), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset", 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", 0, 32'(busy_w[0]), 0);
        chk("idle_done", 0, 32'(done_w[0]), 0);
        chk("idle_vec",  0, 32'({in2_w[0], in1_w[0]}), 0);
        run(0, M_OR, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
